// File: rtl/dcache_nway_if.sv
// Datapath-side and memory-side signal bundle of dcache_nway.
// The cache takes the slave modport; the datapath/memory side takes master.
interface dcache_nway_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache with LRU ages,
// a word-serial writeback/fill engine and a halt-triggered flush of dirty lines.
module dcache_nway #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic         CLK,
  input  logic         RST,
  dcache_nway_if.slave bus
);

  localparam int unsigned OB  = $clog2(BLOCK_WORDS);
  localparam int unsigned IB  = $clog2(SETS);
  localparam int unsigned AB  = $clog2(WAYS);
  localparam int unsigned OBW = (OB == 0) ? 1 : OB;
  localparam int unsigned IBW = (IB == 0) ? 1 : IB;
  localparam int unsigned TB  = 30 - OB - IB;

  localparam logic [OBW-1:0] LAST_WORD = OBW'(BLOCK_WORDS - 1);
  localparam logic [IBW-1:0] LAST_SET  = IBW'(SETS - 1);
  localparam logic [AB-1:0]  LAST_WAY  = AB'(WAYS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_FLUSHED} state_t;
  typedef logic [WAYS-1:0][AB-1:0] age_row_t;

  state_t         state_q, state_d;
  logic [OBW-1:0] ctr_q, ctr_d;
  logic [AB-1:0]  vic_q, vic_d;
  logic [IBW-1:0] fset_q, fset_d;
  logic [AB-1:0]  fway_q, fway_d;
  logic           flushed_q, flushed_d;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];
  age_row_t        age_q   [SETS];
  age_row_t        age_d   [SETS];
  logic [TB-1:0]   tag_q   [SETS][WAYS];
  logic [TB-1:0]   tag_d   [SETS][WAYS];
  logic [31:0]     data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [31:0]     data_d  [SETS][WAYS][BLOCK_WORDS];

  logic [TB-1:0]  req_tag;
  logic [IBW-1:0] req_idx;
  logic [OBW-1:0] req_off;
  logic           hit;
  logic [AB-1:0]  hit_way;
  logic           vic_found;
  logic [AB-1:0]  vic_sel;
  logic           flush_adv;
  logic           addr_byte_unused;

  // The used way becomes youngest; an invalid way is treated as oldest so
  // that every valid way ages and valid ages stay distinct.
  function automatic age_row_t touch(input age_row_t ages, input logic [WAYS-1:0] vld,
                                     input logic [AB-1:0] used);
    age_row_t     nxt;
    logic [AB-1:0] old;
    nxt = ages;
    old = vld[used] ? ages[used] : LAST_WAY;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (vld[w] && (AB'(w) != used) && (ages[w] < old)) nxt[w] = ages[w] + 1'b1;
    end
    nxt[used] = '0;
    return nxt;
  endfunction

  function automatic logic [31:0] mk_addr(input logic [TB-1:0] t, input logic [IBW-1:0] i,
                                          input logic [OBW-1:0] o);
    return (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB)) | (32'(o) << 2);
  endfunction

  assign addr_byte_unused = ^bus.dmemaddr[1:0];

  always_comb begin
    req_tag = bus.dmemaddr[31 -: TB];
    req_idx = IBW'((bus.dmemaddr >> (2 + OB)) & (SETS - 1));
    req_off = OBW'((bus.dmemaddr >> 2) & (BLOCK_WORDS - 1));
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AB'(w);
      end
    end
  end

  always_comb begin
    vic_found = 1'b0;
    vic_sel   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_q[req_idx][w] && !vic_found) begin
        vic_found = 1'b1;
        vic_sel   = AB'(w);
      end
    end
    if (!vic_found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == LAST_WAY) vic_sel = AB'(w);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    vic_d        = vic_q;
    fset_d       = fset_q;
    fway_d       = fway_q;
    flushed_d    = flushed_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    age_d        = age_q;
    tag_d        = tag_q;
    data_d       = data_q;
    flush_adv    = 1'b0;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.halt) begin
          state_d = S_FLUSH;
          fset_d  = '0;
          fway_d  = '0;
          ctr_d   = '0;
        end else if (bus.dmemREN || bus.dmemWEN) begin
          if (hit) begin
            bus.dhit       = 1'b1;
            age_d[req_idx] = touch(age_q[req_idx], valid_q[req_idx], hit_way);
            if (bus.dmemREN) begin
              bus.dmemload = data_q[req_idx][hit_way][req_off];
            end else begin
              data_d[req_idx][hit_way][req_off] = bus.dmemstore;
              dirty_d[req_idx][hit_way]         = 1'b1;
            end
          end else begin
            vic_d   = vic_sel;
            ctr_d   = '0;
            state_d = (valid_q[req_idx][vic_sel] && dirty_q[req_idx][vic_sel]) ? S_WB : S_FILL;
          end
        end
      end

      S_WB: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = mk_addr(tag_q[req_idx][vic_q], req_idx, ctr_q);
        bus.dstore = data_q[req_idx][vic_q][ctr_q];
        if (!bus.dwait) begin
          if (ctr_q == LAST_WORD) begin
            ctr_d   = '0;
            state_d = S_FILL;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end

      S_FILL: begin
        bus.dREN  = 1'b1;
        bus.daddr = mk_addr(req_tag, req_idx, ctr_q);
        if (!bus.dwait) begin
          data_d[req_idx][vic_q][ctr_q] = bus.dload;
          if (ctr_q == LAST_WORD) begin
            tag_d[req_idx][vic_q]   = req_tag;
            valid_d[req_idx][vic_q] = 1'b1;
            dirty_d[req_idx][vic_q] = 1'b0;
            age_d[req_idx]          = touch(age_q[req_idx], valid_q[req_idx], vic_q);
            ctr_d                   = '0;
            state_d                 = S_IDLE;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          bus.dWEN   = 1'b1;
          bus.daddr  = mk_addr(tag_q[fset_q][fway_q], fset_q, ctr_q);
          bus.dstore = data_q[fset_q][fway_q][ctr_q];
          if (!bus.dwait) begin
            if (ctr_q == LAST_WORD) begin
              ctr_d                   = '0;
              dirty_d[fset_q][fway_q] = 1'b0;
              flush_adv               = 1'b1;
            end else begin
              ctr_d = ctr_q + 1'b1;
            end
          end
        end else begin
          flush_adv = 1'b1;
        end
        // Way-minor, set-major scan; the final entry retires straight into FLUSHED.
        if (flush_adv) begin
          if (fway_q == LAST_WAY) begin
            fway_d = '0;
            if (fset_q == LAST_SET) begin
              state_d   = S_FLUSHED;
              flushed_d = 1'b1;
            end else begin
              fset_d = fset_q + 1'b1;
            end
          end else begin
            fway_d = fway_q + 1'b1;
          end
        end
      end

      S_FLUSHED: flushed_d = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.flushed = flushed_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      vic_q     <= '0;
      fset_q    <= '0;
      fway_q    <= '0;
      flushed_q <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        age_q[s]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      vic_q     <= vic_d;
      fset_q    <= fset_d;
      fway_q    <= fway_d;
      flushed_q <= flushed_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      age_q     <= age_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: vector table of accesses with expected latency
// and load data, plus sequences for eviction writeback, flush and reset-in-fill.
module tb_dcache_nway;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_nway_if bus ();

  dcache_nway #(.WAYS(2), .SETS(8), .BLOCK_WORDS(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Memory: unwritten words read 0xAAAA0000+addr; each transfer waits 2 cycles
  // with dwait=1 and completes in the third.
  bit [31:0]   mem   [1024];
  bit          wr_ok [1024];
  int unsigned wait_cnt;
  typedef struct { logic [31:0] a; logic [31:0] d; } wb_t;
  wb_t wb_log [$];

  assign bus.dwait = (bus.dREN || bus.dWEN) && (wait_cnt != 2);
  assign bus.dload = wr_ok[bus.daddr[11:2]] ? mem[bus.daddr[11:2]] : 32'hAAAA0000 + bus.daddr;

  always @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 0;
    end else if (bus.dREN || bus.dWEN) begin
      if (wait_cnt == 2) begin
        wait_cnt <= 0;
        if (bus.dWEN) begin
          mem[bus.daddr[11:2]]   <= bus.dstore;
          wr_ok[bus.daddr[11:2]] <= 1'b1;
          wb_log.push_back('{bus.daddr, bus.dstore});
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_store = '0;
  always begin
    @(negedge clk);
    #2;
    if (bus.dREN || bus.dWEN) begin
      chk("mem_rw_exclusive", 32'(bus.dREN & bus.dWEN), 0);
      if (prev_wait) begin
        chk("daddr_stable", bus.daddr, prev_addr);
        chk("dstore_stable", bus.dstore, prev_store);
      end
    end
    prev_wait  <= (bus.dREN || bus.dWEN) && bus.dwait && !rst;
    prev_addr  <= bus.daddr;
    prev_store <= bus.dstore;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.dmemREN   = 1'b0;
    bus.dmemWEN   = 1'b0;
    bus.dmemaddr  = '0;
    bus.dmemstore = '0;
    bus.halt      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_dhit", 32'(bus.dhit), 0);
    chk("rst_dmemload", bus.dmemload, 0);
    chk("rst_dREN", 32'(bus.dREN), 0);
    chk("rst_dWEN", 32'(bus.dWEN), 0);
    chk("rst_daddr", bus.daddr, 0);
    chk("rst_dstore", bus.dstore, 0);
    chk("rst_flushed", 32'(bus.flushed), 0);
    rst = 1'b0;
    wb_log.delete();
  endtask

  // Presents a request at a falling edge and holds it until dhit (bounded).
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] ld,
                        output logic mact);
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.dmemaddr  = addr;
    bus.dmemstore = wdata;
    #1;
    lat = 0;
    while (!bus.dhit && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
    end
    ld   = bus.dmemload;
    mact = bus.dREN | bus.dWEN;
    @(negedge clk);
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic check_wb(input string tag, input wb_t exp [4]);
    chk({tag, "_wb_count"}, 32'(wb_log.size()), 4);
    for (int k = 0; k < 4 && k < wb_log.size(); k++) begin
      chk($sformatf("%s_wb%0d_addr", tag, k), wb_log[k].a, exp[k].a);
      chk($sformatf("%s_wb%0d_data", tag, k), wb_log[k].d, exp[k].d);
    end
  endtask

  typedef struct {
    bit          do_rst;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_ld;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];
  wb_t  exp_g2 [4];
  wb_t  exp_fl [4];

  initial begin
    int          lat;
    int          n;
    logic [31:0] ld;
    logic        mact;

    // Clean miss = 2 words x 3 cycles + 1; dirty miss adds 6 writeback cycles.
    vt[0]  = '{1, 1, 0, 32'h100, 32'h0,        7,  32'hAAAA0100};
    vt[1]  = '{0, 1, 0, 32'h104, 32'h0,        0,  32'hAAAA0104};
    vt[2]  = '{0, 0, 1, 32'h100, 32'hDEADBEEF, 0,  32'h0};
    vt[3]  = '{0, 1, 0, 32'h100, 32'h0,        0,  32'hDEADBEEF};
    vt[4]  = '{1, 0, 1, 32'h000, 32'h11111111, 7,  32'h0};
    vt[5]  = '{0, 0, 1, 32'h040, 32'h22222222, 7,  32'h0};
    vt[6]  = '{0, 0, 1, 32'h080, 32'h33333333, 13, 32'h0};
    vt[7]  = '{0, 1, 0, 32'h000, 32'h0,        13, 32'h11111111};
    vt[8]  = '{0, 1, 0, 32'h080, 32'h0,        0,  32'h33333333};
    vt[9]  = '{1, 1, 0, 32'h200, 32'h0,        7,  32'hAAAA0200};
    vt[10] = '{0, 1, 0, 32'h240, 32'h0,        7,  32'hAAAA0240};
    vt[11] = '{0, 1, 0, 32'h200, 32'h0,        0,  32'hAAAA0200};
    vt[12] = '{0, 1, 0, 32'h280, 32'h0,        7,  32'hAAAA0280};
    vt[13] = '{0, 1, 0, 32'h200, 32'h0,        0,  32'hAAAA0200};
    vt[14] = '{0, 1, 0, 32'h240, 32'h0,        7,  32'hAAAA0240};
    vt[15] = '{0, 1, 1, 32'h240, 32'h55555555, 0,  32'hAAAA0240};
    vt[16] = '{0, 1, 0, 32'h240, 32'h0,        0,  32'hAAAA0240};

    exp_g2[0] = '{32'h000, 32'h11111111};
    exp_g2[1] = '{32'h004, 32'hAAAA0004};
    exp_g2[2] = '{32'h040, 32'h22222222};
    exp_g2[3] = '{32'h044, 32'hAAAA0044};
    exp_fl[0] = '{32'h008, 32'h01010101};
    exp_fl[1] = '{32'h00C, 32'hAAAA000C};
    exp_fl[2] = '{32'h010, 32'h02020202};
    exp_fl[3] = '{32'h014, 32'hAAAA0014};

    idle_inputs();
    for (int i = 0; i < NV; i++) begin
      if (vt[i].do_rst) do_reset();
      access(vt[i].ren, vt[i].wen, vt[i].addr, vt[i].wdata, lat, ld, mact);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      if (vt[i].ren) chk($sformatf("v%0d_load", i), ld, vt[i].exp_ld);
      if (vt[i].lat == 0) chk($sformatf("v%0d_hit_no_mem", i), 32'(mact), 0);
      if (i == 3 || i == 16) chk($sformatf("v%0d_no_writeback", i), 32'(wb_log.size()), 0);
      if (i == 8) check_wb("evict", exp_g2);
    end

    // Flush: dirty lines in sets 1 and 2, clean line in set 3.
    do_reset();
    access(1'b0, 1'b1, 32'h008, 32'h01010101, lat, ld, mact);
    access(1'b0, 1'b1, 32'h010, 32'h02020202, lat, ld, mact);
    access(1'b1, 1'b0, 32'h018, 32'h0, lat, ld, mact);
    chk("pre_halt_flushed", 32'(bus.flushed), 0);
    chk("pre_halt_no_writeback", 32'(wb_log.size()), 0);
    bus.halt = 1'b1;
    n = 0;
    while (!bus.flushed && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("flush_done", 32'(bus.flushed), 1);
    chk("flush_cycles", 32'(n), 27);
    check_wb("flush", exp_fl);
    bus.halt     = 1'b0;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h018;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("flushed_sticky_%0d", c), 32'(bus.flushed), 1);
      chk($sformatf("flushed_no_hit_%0d", c), 32'(bus.dhit), 0);
      chk($sformatf("flushed_no_mem_%0d", c), 32'(bus.dREN | bus.dWEN), 0);
    end
    chk("flushed_wb_total", 32'(wb_log.size()), 4);
    bus.dmemREN = 1'b0;

    // Reset while a fill word is still pending.
    do_reset();
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("fill_dREN", 32'(bus.dREN), 1);
    chk("fill_dwait", 32'(bus.dwait), 1);
    chk("fill_daddr", bus.daddr, 32'h300);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_fill_dREN", 32'(bus.dREN), 0);
    chk("rst_fill_dhit", 32'(bus.dhit), 0);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'h300, 32'h0, lat, ld, mact);
    chk("refill_latency", 32'(lat), 7);
    chk("refill_load", ld, 32'hAAAA0300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
